// File: rtl/shift_reg_ctrl.sv
// Occupancy/handshake sequencer for an external Size-stage shift line with flush support.
// Strobes the line only when it can move; a beat leaves the last stage only on a shift.
module shift_reg_ctrl #(
  parameter  int unsigned Size = 4,
  localparam int unsigned CntW = $clog2(Size + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  input  logic            flush_i,
  output logic            sr_we_o,
  output logic [CntW-1:0] count_o,
  output logic            busy_o,
  output logic            flush_done_o
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  state_e            state_q, state_d;
  logic [Size-1:0]   vld_q, vld_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              flush_done_q, flush_done_d;

  logic last, room, in_flush, shift_req, sr_we, newbit;

  always_comb begin
    last      = vld_q[Size-1];
    room      = !last | out_ready_i;
    in_flush  = (state_q == FLUSH);
    shift_req = in_flush ? 1'b1 : in_valid_i;
    // Gating with rst_ni keeps every output low while reset is held.
    sr_we     = shift_req & room & rst_ni;
    newbit    = !in_flush;

    vld_d = vld_q;
    if (sr_we) begin
      vld_d[0] = newbit;
      for (int i = 1; i < Size; i++) vld_d[i] = vld_q[i-1];
    end

    count_d = count_q;
    case ({sr_we & newbit, sr_we & last})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sr_we)        state_d = flush_i ? FLUSH : RUN;
        else if (flush_i) flush_done_d = 1'b1;
      end
      RUN: begin
        if (flush_i)             state_d = FLUSH;
        else if (count_d == '0)  state_d = IDLE;
      end
      FLUSH: begin
        if (vld_d == '0) begin
          state_d      = IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      vld_q        <= '0;
      count_q      <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vld_q        <= vld_d;
      count_q      <= count_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign sr_we_o      = sr_we;
  assign in_ready_o   = !in_flush & room & rst_ni;
  assign out_valid_o  = last & shift_req;
  assign count_o      = count_q;
  assign busy_o       = in_flush;
  assign flush_done_o = flush_done_q;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Bench for shift_reg_ctrl: Size=4 and Size=1 instances on shared stimulus, with line/data scoreboards.
module tb_shift_reg_ctrl;

  logic clk = 1'b0;
  logic rst_n, in_valid, out_ready, flush;
  logic [7:0] data_in;

  logic       ir4, ov4, we4, busy4, fd4;
  logic [2:0] cnt4;
  logic       ir1, ov1, we1, busy1, fd1;
  logic [0:0] cnt1;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  shift_reg_ctrl #(.Size(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(ir4),
    .out_valid_o(ov4), .out_ready_i(out_ready), .flush_i(flush), .sr_we_o(we4),
    .count_o(cnt4), .busy_o(busy4), .flush_done_o(fd4)
  );

  shift_reg_ctrl #(.Size(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(ir1),
    .out_valid_o(ov1), .out_ready_i(out_ready), .flush_i(flush), .sr_we_o(we1),
    .count_o(cnt1), .busy_o(busy1), .flush_done_o(fd1)
  );

  // Bench-side data lines, shifted by each controller's strobe.
  logic [7:0] line4 [4];
  logic [7:0] line1 [1];
  logic [7:0] q4[$];
  logic [7:0] q1[$];

  typedef struct {
    logic       iv, ordy, fl;
    logic       ir, ov, we, busy, fd;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs [40];
  int   nvec = 0;

  task automatic addv(input logic iv, ordy, fl, ir, ov, we, busy, fd, input logic [2:0] cnt);
    vecs[nvec] = '{iv, ordy, fl, ir, ov, we, busy, fd, cnt};
    nvec++;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, ordy, fl);
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    data_in   = data_in + 8'd1;
    #1;
  endtask

  // Scoreboard compare, then clock edge and line-model update.
  task automatic commit();
    logic [7:0] exp;
    logic       s4, s1, p4, p1;
    if (ov4 && out_ready) begin
      if (q4.size() == 0) chk("sb4_empty", 8'd1, 8'd0);
      else begin exp = q4.pop_front(); chk("sb4_data", line4[3], exp); end
    end
    if (ov1 && out_ready) begin
      if (q1.size() == 0) chk("sb1_empty", 8'd1, 8'd0);
      else begin exp = q1.pop_front(); chk("sb1_data", line1[0], exp); end
    end
    s4 = we4; s1 = we1;
    p4 = in_valid & ir4; p1 = in_valid & ir1;
    @(posedge clk);
    if (p4) q4.push_back(data_in);
    if (p1) q1.push_back(data_in);
    if (s4) begin
      line4[3] = line4[2]; line4[2] = line4[1]; line4[1] = line4[0]; line4[0] = data_in;
    end
    if (s1) line1[0] = data_in;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1; data_in = 8'h00;
    for (int i = 0; i < 4; i++) begin line4[i] = 8'hxx; end
    line1[0] = 8'hxx;

    //   iv ordy fl | ir ov we busy fd cnt   (count is the pre-edge value)
    addv(1, 1, 0,  1, 0, 1, 0, 0, 3'd0);   // A..D fill
    addv(1, 1, 0,  1, 0, 1, 0, 0, 3'd1);
    addv(1, 1, 0,  1, 0, 1, 0, 0, 3'd2);
    addv(1, 1, 0,  1, 0, 1, 0, 0, 3'd3);
    addv(1, 1, 0,  1, 1, 1, 0, 0, 3'd4);   // E pushes A out
    addv(1, 0, 0,  0, 1, 0, 0, 0, 3'd4);   // downstream stall
    addv(1, 0, 0,  0, 1, 0, 0, 0, 3'd4);
    addv(1, 1, 0,  1, 1, 1, 0, 0, 3'd4);   // release: one shift
    addv(0, 1, 1,  1, 0, 0, 0, 0, 3'd4);   // flush full line
    addv(0, 1, 0,  0, 1, 1, 1, 0, 3'd4);
    addv(0, 1, 0,  0, 1, 1, 1, 0, 3'd3);
    addv(0, 1, 0,  0, 1, 1, 1, 0, 3'd2);
    addv(0, 1, 0,  0, 1, 1, 1, 0, 3'd1);
    addv(0, 1, 0,  1, 0, 0, 0, 1, 3'd0);
    addv(0, 1, 0,  1, 0, 0, 0, 0, 3'd0);
    addv(1, 1, 0,  1, 0, 1, 0, 0, 3'd0);   // A,B then flush
    addv(1, 1, 0,  1, 0, 1, 0, 0, 3'd1);
    addv(0, 1, 1,  1, 0, 0, 0, 0, 3'd2);
    addv(0, 1, 0,  0, 0, 1, 1, 0, 3'd2);
    addv(0, 1, 0,  0, 0, 1, 1, 0, 3'd2);
    addv(0, 1, 0,  0, 1, 1, 1, 0, 3'd2);
    addv(0, 1, 0,  0, 1, 1, 1, 0, 3'd1);
    addv(0, 1, 0,  1, 0, 0, 0, 1, 3'd0);
    addv(1, 1, 0,  1, 0, 1, 0, 0, 3'd0);   // flush with accepted beat C
    addv(1, 1, 1,  1, 0, 1, 0, 0, 3'd1);
    addv(1, 1, 0,  0, 0, 1, 1, 0, 3'd2);
    addv(1, 0, 0,  0, 0, 1, 1, 0, 3'd2);   // last=0: keeps moving
    addv(1, 0, 0,  0, 1, 0, 1, 0, 3'd2);   // last=1: stalls
    addv(0, 1, 0,  0, 1, 1, 1, 0, 3'd2);
    addv(0, 1, 0,  0, 1, 1, 1, 0, 3'd1);
    addv(0, 1, 0,  1, 0, 0, 0, 1, 3'd0);
    addv(0, 1, 1,  1, 0, 0, 0, 0, 3'd0);   // empty flush
    addv(0, 1, 0,  1, 0, 0, 0, 1, 3'd0);
    addv(0, 1, 0,  1, 0, 0, 0, 0, 3'd0);

    // Reset held with active inputs: everything low.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", {7'd0, ir4}, 8'd0);
    chk("rst_sr_we",    {7'd0, we4}, 8'd0);
    chk("rst_out_valid",{7'd0, ov4}, 8'd0);
    chk("rst_busy",     {7'd0, busy4}, 8'd0);
    chk("rst_count",    {5'd0, cnt4}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0;
    #1;
    chk("idle_sr_we", {7'd0, we4}, 8'd0);
    chk("idle_out_valid", {7'd0, ov4}, 8'd0);
    chk("idle_fd", {7'd0, fd4}, 8'd0);
    chk("idle_count", {5'd0, cnt4}, 8'd0);
    commit();

    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl);
      chk($sformatf("v%0d_in_ready", i),  {7'd0, ir4},   {7'd0, vecs[i].ir});
      chk($sformatf("v%0d_out_valid", i), {7'd0, ov4},   {7'd0, vecs[i].ov});
      chk($sformatf("v%0d_sr_we", i),     {7'd0, we4},   {7'd0, vecs[i].we});
      chk($sformatf("v%0d_busy", i),      {7'd0, busy4}, {7'd0, vecs[i].busy});
      chk($sformatf("v%0d_flush_done", i),{7'd0, fd4},   {7'd0, vecs[i].fd});
      chk($sformatf("v%0d_count", i),     {5'd0, cnt4},  {5'd0, vecs[i].cnt});
      commit();
    end

    // Reset in the middle of a flush holding three beats.
    for (int i = 0; i < 3; i++) begin drive(1, 1, 0); commit(); end
    drive(0, 1, 1); commit();
    drive(0, 1, 0);
    chk("mf_busy", {7'd0, busy4}, 8'd1);
    chk("mf_count", {5'd0, cnt4}, 8'd3);
    rst_n = 1'b0;
    #1;
    chk("mf_rst_busy",  {7'd0, busy4}, 8'd0);
    chk("mf_rst_count", {5'd0, cnt4},  8'd0);
    chk("mf_rst_sr_we", {7'd0, we4},   8'd0);
    chk("mf_rst_ov",    {7'd0, ov4},   8'd0);
    q4.delete(); q1.delete();
    commit();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_fd_a", {7'd0, fd4}, 8'd0);
    commit();
    drive(0, 1, 0);
    chk("post_rst_fd_b", {7'd0, fd4}, 8'd0);
    commit();

    // Fresh pushes: Size=4 fills, Size=1 emits on every push after the first.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0);
      chk($sformatf("p%0d_we4", i),   {7'd0, we4}, 8'd1);
      chk($sformatf("p%0d_cnt4", i),  {5'd0, cnt4}, 8'(i));
      chk($sformatf("p%0d_ov4", i),   {7'd0, ov4}, 8'd0);
      chk($sformatf("p%0d_ov1", i),   {7'd0, ov1}, (i == 0) ? 8'd0 : 8'd1);
      chk($sformatf("p%0d_cnt1", i),  {7'd0, cnt1}, (i == 0) ? 8'd0 : 8'd1);
      commit();
    end
    drive(0, 1, 0);
    chk("final_cnt4", {5'd0, cnt4}, 8'd4);
    chk("final_cnt1", {7'd0, cnt1}, 8'd1);
    chk("final_ov1_nopush", {7'd0, ov1}, 8'd0);
    commit();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/shift_reg_ctrl.md
Name: shift_reg_ctrl

Overview:
- Sequencer for a `Size`-stage `shift_reg` delay line, which shifts all stages together when `we_i` is high.
- Tracks which stages hold valid data, drives the line's write enable, and wraps the line in valid/ready stream handshakes on both sides.
- Provides a flush command that pushes bubbles in until the line is empty.
- The datapath stays external: upstream data drives the line's `data_i` directly, and the line's `data_o` is the stream output data.

Parameters:
- `Size`, 4, number of stages in the controlled line; legal range 1..64.
- `CntW`, `$clog2(Size+1)`, width of the occupancy count; derived, not overridden.

Ports:
- `clk_i`  input  1  clock; all state updates on the rising edge.
- `rst_ni`  input  1  asynchronous active-low reset.
- `in_valid_i`  input  1  upstream beat present on the line's `data_i`.
- `in_ready_o`  output  1  beat accepted this cycle when `in_valid_i` is also high.
- `out_valid_o`  output  1  the line's `data_o` holds a valid beat being emitted this cycle.
- `out_ready_i`  input  1  downstream accepts.
- `flush_i`  input  1  one-cycle flush request.
- `sr_we_o`  output  1  write enable to the shift line (the shift strobe).
- `count_o`  output  CntW  number of valid stages.
- `busy_o`  output  1  high in FLUSH state.
- `flush_done_o`  output  1  one-cycle pulse when a flush completes.

Behaviour:
- Internal state:
  - `vld[Size-1:0]` shadows the line: bit 0 is the newest stage, bit `Size-1` is the oldest (the stage driving `data_o`).
  - FSM state is IDLE, RUN or FLUSH.
- Reset (async, `rst_ni` = 0): `vld` = 0, state = IDLE, `count_o` = 0. All outputs low: `in_ready_o`, `out_valid_o`, `sr_we_o`, `busy_o`, `flush_done_o`.
- Combinational signals:
  - `last` = `vld[Size-1]`.
  - `room` = `!last | out_ready_i`.
  - `shift_req` = `in_valid_i` in IDLE/RUN; `shift_req` = 1 in FLUSH.
  - `sr_we_o` = `shift_req & room`.
  - `in_ready_o` = `room` in IDLE/RUN; `in_ready_o` = 0 in FLUSH.
  - `out_valid_o` = `last & shift_req`. Data leaves only when the line shifts, so a beat that reaches the last stage waits there until the next push or a flush.
  - Consequence: `out_valid_o & out_ready_i` implies `sr_we_o`, so every handshake moves exactly one beat.
- On the rising edge with `sr_we_o` = 1:
  - `vld` <= {`vld[Size-2:0]`, `newbit`}.
  - `newbit` = 1 in IDLE/RUN (input beat accepted), 0 in FLUSH (bubble).
  - For `Size` = 1, `vld` <= `newbit`.
- `count_o` = popcount(`vld`). It is a register updated alongside `vld`:
  - +1 for an accepted input.
  - −1 for an emitted output.
  - Both or neither: no change.
  - It never exceeds `Size` and never underflows.
- Latency: a beat accepted at edge n appears on `data_o` after `Size` shifts, not after a fixed number of cycles.
- FSM:
  - IDLE (`vld` == 0):
    - an accepted beat → RUN.
    - `flush_i` → ignored, but `flush_done_o` still pulses on the next cycle (empty flush completes trivially).
  - RUN:
    - `count` reaches 0 after an edge → IDLE.
    - `flush_i` = 1 → FLUSH next cycle. An input handshake in the same cycle is still honoured; the flush covers that beat too.
  - FLUSH:
    - shifts a bubble every cycle `room` holds; stalls while `last` & !`out_ready_i`.
    - the edge on which `vld` becomes 0 → IDLE, with `flush_done_o` = 1 for the following cycle.
    - `flush_i` while in FLUSH is ignored.
- Flush duration: at most `Size` shifting cycles, because all bubbles ahead of the oldest valid beat also shift out.
- Reset mid-flush: immediate IDLE, no `flush_done_o` pulse.
- The downstream may hold `out_ready_i` low indefinitely. The controller then stalls with `in_ready_o` = 0 only when `last` = 1; while `last` = 0 it keeps filling.

Test Plan:
- `Size` = 4, reset held then released, no stimulus → all outputs 0, `count_o` = 0, state IDLE.
- Push beats A,B,C,D with `out_ready_i` = 1 → `out_valid_o` = 0 for 4 pushes, `count_o` = 4. Push E → `out_valid_o` = 1 with A on `data_o` that cycle, `count_o` stays 4.
- Fill to 4, `out_ready_i` = 0, `in_valid_i` = 1 → `in_ready_o` = 0, `sr_we_o` = 0, `count_o` holds 4. Raise `out_ready_i` → one shift, A emitted, E accepted.
- Push A,B (`count_o` = 2), pulse `flush_i` → `busy_o` = 1, A then B emitted on `out_valid_o` in shifting cycles 3 and 4 of the flush. `flush_done_o` pulses once, `count_o` = 0, IDLE.
- `flush_i` together with an accepted beat C (`count_o` 1 → 2) → C is included in the flush. During FLUSH, `in_ready_o` = 0 even with `in_valid_i` = 1.
- Drop `rst_ni` in the middle of a flush with `count_o` = 3 → outputs clear asynchronously and no `flush_done_o` pulse. After release, a new push is accepted normally. The same bench is repeated with `Size` = 1: every push after the first emits.
